// File: rtl/io_pkg.sv
// Shared I/O map constants, register selects and helpers
// for the memory-mapped board I/O controller.
package io_pkg;

  localparam logic [11:0] OFF_LEDR = 12'h000;
  localparam logic [11:0] OFF_LEDG = 12'h010;
  localparam logic [11:0] OFF_HEX  = 12'h020;
  localparam logic [11:0] OFF_LCD  = 12'h030;
  localparam logic [11:0] OFF_MODE = 12'h040;
  localparam logic [11:0] OFF_SW   = 12'h800;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LEDR,
    SEL_LEDG,
    SEL_HEX,
    SEL_LCD,
    SEL_MODE,
    SEL_SW
  } reg_sel_e;

  // Active-low segments, bit order g..a
  function automatic logic [6:0] seg_decode(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/io_sw_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer
// for the board switch inputs.
module io_sw_debounce #(
  parameter int SW_W       = 32,
  parameter int DEB_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_sw
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LD  = CW'(DEB_CYCLES - 2);

  logic [SW_W-1:0] sync1, sync2, prev;
  logic [CW-1:0]   cnt;

  // Load on the edge the counter reaches its terminal value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      cnt   <= '0;
      o_sw  <= '0;
    end else begin
      sync1 <= i_sw;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        cnt <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (cnt >= CNT_LD)  o_sw <= sync2;
      end
    end
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped board I/O: LEDs, LCD, seven-segment
// digits and debounced switches on a single bus port.
module io_mmio_ctrl
  import io_pkg::*;
#(
  parameter int NUM_HEX    = 8,
  parameter int SW_W       = 32,
  parameter int LED_W      = 32,
  parameter int DEB_CYCLES = 16,
  parameter int ADDR_W     = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_bmask,
  input  logic                 i_wren,
  input  logic                 i_rden,
  output logic [31:0]          o_rdata,
  output logic                 o_rvalid,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [LED_W-1:0]     o_io_ledr,
  output logic [LED_W-1:0]     o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*NUM_HEX-1:0] o_io_hex
);

  localparam int HEX_WORDS = (NUM_HEX + 3) / 4;
  localparam logic [ADDR_W-1:0] A_LEDR = ADDR_W'(OFF_LEDR);
  localparam logic [ADDR_W-1:0] A_LEDG = ADDR_W'(OFF_LEDG);
  localparam logic [ADDR_W-1:0] A_HEX  = ADDR_W'(OFF_HEX);
  localparam logic [ADDR_W-1:0] A_LCD  = ADDR_W'(OFF_LCD);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(OFF_MODE);
  localparam logic [ADDR_W-1:0] A_SW   = ADDR_W'(OFF_SW);

  logic [ADDR_W-1:0] wa;
  logic [1:0]        hex_idx;
  logic              unused_addr;
  reg_sel_e          sel;
  logic [31:0]       rd_mux;

  logic [LED_W-1:0]   ledr_q, ledg_q;
  logic [31:0]        lcd_q;
  logic [NUM_HEX-1:0] mode_q;
  logic [6:0]         hex_q [NUM_HEX];
  logic [SW_W-1:0]    sw_stable;

  assign wa          = {i_addr[ADDR_W-1:2], 2'b00};
  assign hex_idx     = wa[3:2];
  assign unused_addr = ^i_addr[1:0];

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (wa == A_LEDR): sel = SEL_LEDR;
      (wa == A_LEDG): sel = SEL_LEDG;
      (wa[ADDR_W-1:4] == A_HEX[ADDR_W-1:4]
        && int'(hex_idx) < HEX_WORDS):
        sel = SEL_HEX;
      (wa == A_LCD):  sel = SEL_LCD;
      (wa == A_MODE): sel = SEL_MODE;
      (wa == A_SW):   sel = SEL_SW;
      default:        sel = SEL_NONE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k < NUM_HEX; k++)
        hex_q[k] <= 7'h7F;
    end else if (i_wren) begin
      unique case (sel)
        SEL_LEDR: ledr_q <= LED_W'(byte_merge(
          32'(ledr_q), i_wdata, i_bmask));
        SEL_LEDG: ledg_q <= LED_W'(byte_merge(
          32'(ledg_q), i_wdata, i_bmask));
        SEL_LCD:  lcd_q <= byte_merge(
          lcd_q, i_wdata, i_bmask);
        SEL_MODE: mode_q <= NUM_HEX'(byte_merge(
          32'(mode_q), i_wdata, i_bmask));
        SEL_HEX:
          for (int k = 0; k < NUM_HEX; k++)
            if (int'(hex_idx) == k / 4
                && i_bmask[k % 4])
              hex_q[k] <= i_wdata[8*(k%4) +: 7];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_LEDR: rd_mux = 32'(ledr_q);
      SEL_LEDG: rd_mux = 32'(ledg_q);
      SEL_LCD:  rd_mux = lcd_q;
      SEL_MODE: rd_mux = 32'(mode_q);
      SEL_SW:   rd_mux = 32'(sw_stable);
      SEL_HEX:
        for (int k = 0; k < NUM_HEX; k++)
          if (int'(hex_idx) == k / 4)
            rd_mux[8*(k%4) +: 8] = {1'b0, hex_q[k]};
      default: ;
    endcase
  end

  // Read data samples the pre-write register value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_rden;
      if (i_rden) o_rdata <= rd_mux;
    end
  end

  always_comb begin
    o_io_hex = '1;
    for (int k = 0; k < NUM_HEX; k++)
      o_io_hex[7*k +: 7] = mode_q[k]
        ? seg_decode(hex_q[k][3:0]) : hex_q[k];
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

  io_sw_debounce #(
    .SW_W       (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sw    (i_io_sw),
    .o_sw    (sw_stable)
  );

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Scoreboard bench for io_mmio_ctrl: default instance
// plus a 6-digit, 10-bit-LED instance.
module tb_io_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        wren0, rden0, wren1, rden1;
  logic [31:0] sw;

  logic [31:0] rdata0, ledr0, ledg0, lcd0;
  logic        rvalid0;
  logic [55:0] hex0;
  logic [31:0] rdata1, lcd1;
  logic        rvalid1;
  logic [9:0]  ledr1, ledg1;
  logic [41:0] hex1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] q0[$], q1[$];
  int          c0[$], c1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  io_mmio_ctrl u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_addr(addr), .i_wdata(wdata),
    .i_bmask(bmask), .i_wren(wren0),
    .i_rden(rden0), .o_rdata(rdata0),
    .o_rvalid(rvalid0), .i_io_sw(sw),
    .o_io_ledr(ledr0), .o_io_ledg(ledg0),
    .o_io_lcd(lcd0), .o_io_hex(hex0)
  );

  io_mmio_ctrl #(
    .NUM_HEX(6), .LED_W(10)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_addr(addr), .i_wdata(wdata),
    .i_bmask(bmask), .i_wren(wren1),
    .i_rden(rden1), .o_rdata(rdata1),
    .o_rvalid(rvalid1), .i_io_sw(sw),
    .o_io_ledr(ledr1), .o_io_ledg(ledg1),
    .o_io_lcd(lcd1), .o_io_hex(hex1)
  );

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalid0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u0_rvalid actual=1 expected=0");
      end else begin
        chk("u0_rdata", rdata0, q0.pop_front());
        chk("u0_latency", cyc - c0.pop_front(), 1);
      end
    end
    if (rst_n && rvalid1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u1_rvalid actual=1 expected=0");
      end else begin
        chk("u1_rdata", rdata1, q1.pop_front());
        chk("u1_latency", cyc - c1.pop_front(), 1);
      end
    end
  end

  task automatic bus(
    input int          u,
    input logic [11:0] a,
    input logic [31:0] d,
    input logic [3:0]  m,
    input logic        wr,
    input logic        rd,
    input logic [31:0] exp
  );
    addr = a;
    wdata = d;
    bmask = m;
    if (u == 0) begin
      wren0 = wr;
      rden0 = rd;
      if (rd) begin
        q0.push_back(exp);
        c0.push_back(cyc);
      end
    end else begin
      wren1 = wr;
      rden1 = rd;
      if (rd) begin
        q1.push_back(exp);
        c1.push_back(cyc);
      end
    end
    @(negedge clk);
    wren0 = 0; rden0 = 0;
    wren1 = 0; rden1 = 0;
  endtask

  task automatic wr(
    input int u, input logic [11:0] a,
    input logic [31:0] d, input logic [3:0] m
  );
    bus(u, a, d, m, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic rd(
    input int u, input logic [11:0] a,
    input logic [31:0] exp
  );
    bus(u, a, 32'h0, 4'h0, 1'b0, 1'b1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    addr = '0; wdata = '0; bmask = '0;
    wren0 = 0; rden0 = 0; wren1 = 0; rden1 = 0;
    sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ledr", ledr0, 0);
    chk("rst_hex", hex0, 56'hFF_FFFF_FFFF_FFFF);
    rd(0, 12'h040, 32'h0);
    rd(0, 12'h020, 32'h7F7F7F7F);

    wr(0, 12'h000, 32'h0, 4'hF);
    wr(0, 12'h000, 32'hAABBCCDD, 4'b0101);
    chk("ledr_mask", ledr0, 32'h00BB00DD);
    rd(0, 12'h000, 32'h00BB00DD);

    wr(0, 12'h020, 32'h00000008, 4'hF);
    wr(0, 12'h040, 32'h0, 4'hF);
    chk("hex_raw", hex0[6:0], 7'h08);
    chk("hex_raw_d1", hex0[13:7], 7'h00);
    wr(0, 12'h040, 32'h1, 4'hF);
    chk("hex_dec8", hex0[6:0], 7'h00);
    wr(0, 12'h020, 32'h0000000F, 4'hF);
    chk("hex_decF", hex0[6:0], 7'h0E);
    rd(0, 12'h040, 32'h1);
    rd(0, 12'h020, 32'h0000000F);

    wr(0, 12'h030, 32'h11, 4'hF);
    bus(0, 12'h030, 32'h22, 4'hF, 1'b1, 1'b1, 32'h11);
    chk("lcd_rw", lcd0, 32'h22);
    rd(0, 12'h030, 32'h22);

    wr(0, 12'h050, 32'hDEADBEEF, 4'hF);
    rd(0, 12'h050, 32'h0);
    wr(0, 12'h800, 32'hFFFF, 4'hF);
    rd(0, 12'h800, 32'h0);

    addr = 12'h000;
    rden0 = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rden0 = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid0, 0);
    chk("mid_rst_ledr", ledr0, 0);
    chk("mid_rst_lcd", lcd0, 0);
    chk("mid_rst_hex", hex0, 56'hFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, 12'h040, 32'h0);
    rd(0, 12'h000, 32'h0);

    repeat (20) @(negedge clk);
    sw = 32'h5;
    repeat (17) @(negedge clk);
    rd(0, 12'h800, 32'h0);
    rd(0, 12'h800, 32'h5);

    repeat (5) @(negedge clk);
    sw = 32'h3;
    repeat (8) @(negedge clk);
    rd(0, 12'h800, 32'h5);
    @(negedge clk);
    sw = 32'h5;
    repeat (40) @(negedge clk);
    rd(0, 12'h800, 32'h5);

    wr(1, 12'h020, 32'h04030201, 4'hF);
    wr(1, 12'h024, 32'hFFFFFFFF, 4'hF);
    rd(1, 12'h024, 32'h00007F7F);
    rd(1, 12'h020, 32'h04030201);
    chk("u1_hex", hex1, {7'h7F, 7'h7F, 7'h04,
                         7'h03, 7'h02, 7'h01});
    rd(1, 12'h028, 32'h0);
    wr(1, 12'h010, 32'hFFFFFFFF, 4'hF);
    chk("u1_ledg", ledg1, 10'h3FF);
    rd(1, 12'h010, 32'h3FF);
    @(negedge clk);
    chk("u1_rvalid_low", rvalid1, 0);
    chk("u1_rdata_hold", rdata1, 32'h3FF);

    repeat (4) @(negedge clk);
    chk("sb_drained", q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
